// File: rtl/pipe_pkg.sv
// Shared types and constants for the arbitrated 3-stage arithmetic pipeline.
//  LAT            : pipeline depth from accept edge to FIFO push
//  PIPE_N/PIPE_ID_W: payload and id widths carried in the stage records
//  s1_t/s2_t/s3_t : per-stage records (valid, id, payload)
//  res_t          : output FIFO entry
//  min_obuf_depth : smallest FIFO depth that sustains one result per cycle
package pipe_pkg;

   localparam int unsigned LAT       = 3;
   localparam int unsigned PIPE_N    = 10;
   localparam int unsigned PIPE_ID_W = 2;

   typedef struct packed {
      logic                 valid;
      logic [PIPE_ID_W-1:0] id;
      logic [PIPE_N-1:0]    x1;
      logic [PIPE_N-1:0]    x2;
      logic [PIPE_N-1:0]    d;
   } s1_t;

   typedef struct packed {
      logic                 valid;
      logic [PIPE_ID_W-1:0] id;
      logic [PIPE_N-1:0]    x3;
      logic [PIPE_N-1:0]    d;
   } s2_t;

   typedef struct packed {
      logic                 valid;
      logic [PIPE_ID_W-1:0] id;
      logic [PIPE_N-1:0]    f;
   } s3_t;

   typedef struct packed {
      logic [PIPE_ID_W-1:0] id;
      logic [PIPE_N-1:0]    data;
   } res_t;

   // One slot per stage plus one for the in-flight push and one for the pop bubble.
   function automatic int unsigned min_obuf_depth();
      return LAT + 2;
   endfunction

endpackage

// File: rtl/pipe_arb_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer with wrap.
//  clk, rst_n : clock, async active-low reset
//  req        : per-requester request
//  accept     : grant was taken this cycle; pointer advances past the winner
//  grant      : one-hot grant (combinational)
//  grant_idx  : index of the granted requester (combinational)
module rr_arbiter #(
   parameter  int unsigned NREQ  = 4,
   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic             accept,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] ptr_q;

   // First requester at or after the pointer, wrapping.
   always_comb begin
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         logic [IDX_W-1:0] idx;
         idx = IDX_W'((32'(ptr_q) + k) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

   // Pointer moves only when the grant is actually taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/pipe_arb_sched.sv
// Shares one 3-stage pipeline F = (A+B) + (C-D) + D mod 2^N among NREQ requesters.
//  clk, rst_n          : clock, async active-low reset
//  req_valid/req_ready : per-requester handshake (at most one ready bit high)
//  req_a..req_d        : packed operands, requester i at [i*N +: N]
//  res_valid/res_ready : output FIFO head handshake
//  res_data, res_id    : result and issuing requester
//  busy                : any stage valid or FIFO non-empty
module pipe_arb_sched
   import pipe_pkg::*;
#(
   parameter int unsigned N          = PIPE_N,
   parameter int unsigned NREQ       = 4,
   parameter int unsigned ID_W       = PIPE_ID_W,
   parameter int unsigned OBUF_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   input  logic [NREQ*N-1:0] req_c,
   input  logic [NREQ*N-1:0] req_d,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [N-1:0]      res_data,
   output logic [ID_W-1:0]   res_id,
   output logic              busy
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);
   localparam int unsigned OCC_W = $clog2(OBUF_DEPTH + LAT + 1);

   if (OBUF_DEPTH < min_obuf_depth()) begin : g_depth_chk
      $error("OBUF_DEPTH below minimum for sustained throughput");
   end

   s1_t              s1_q;
   s2_t              s2_q;
   s3_t              s3_q;
   res_t             mem_q [OBUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;

   logic [NREQ-1:0]  grant_c;
   logic [IDX_W-1:0] grant_idx_c;
   logic [OCC_W-1:0] occ_c;
   logic             credit_ok_c;
   logic             accept_c;
   logic             push_c;
   logic             pop_c;
   logic [N-1:0]     a_c, b_c, c_c, d_c;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .accept    (accept_c),
      .grant     (grant_c),
      .grant_idx (grant_idx_c)
   );

   // Credits count every accepted-but-unpopped result from registered state only,
   // so a pop frees a slot one cycle later and res_ready never reaches req_ready.
   always_comb begin
      occ_c       = OCC_W'(s1_q.valid) + OCC_W'(s2_q.valid) + OCC_W'(s3_q.valid) + OCC_W'(cnt_q);
      credit_ok_c = occ_c < OCC_W'(OBUF_DEPTH);
      req_ready   = grant_c & {NREQ{credit_ok_c & rst_n}};
      accept_c    = |(req_valid & req_ready);
      a_c         = req_a[int'(grant_idx_c) * N +: N];
      b_c         = req_b[int'(grant_idx_c) * N +: N];
      c_c         = req_c[int'(grant_idx_c) * N +: N];
      d_c         = req_d[int'(grant_idx_c) * N +: N];
      push_c      = s3_q.valid;
      pop_c       = res_valid & res_ready;
   end

   // Non-stallable pipeline; payloads only load behind a valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q.valid <= accept_c;
         if (accept_c) begin
            s1_q.id <= ID_W'(grant_idx_c);
            s1_q.x1 <= a_c + b_c;
            s1_q.x2 <= c_c - d_c;
            s1_q.d  <= d_c;
         end
         s2_q.valid <= s1_q.valid;
         if (s1_q.valid) begin
            s2_q.id <= s1_q.id;
            s2_q.x3 <= s1_q.x1 + s1_q.x2;
            s2_q.d  <= s1_q.d;
         end
         s3_q.valid <= s2_q.valid;
         if (s2_q.valid) begin
            s3_q.id <= s2_q.id;
            s3_q.f  <= s2_q.x3 + s2_q.d;
         end
      end
   end

   // Circular output buffer; credits rule out a push while full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_c) begin
            mem_q[wr_ptr_q] <= '{id: s3_q.id, data: s3_q.f};
            wr_ptr_q <= (wr_ptr_q == PTR_W'(OBUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(OBUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         cnt_q <= cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   always_comb begin
      res_valid = (cnt_q != '0);
      res_data  = mem_q[rd_ptr_q].data;
      res_id    = mem_q[rd_ptr_q].id;
      busy      = s1_q.valid | s2_q.valid | s3_q.valid | res_valid;
   end

endmodule

// File: tb/tb_pipe_arb_sched.sv
// Self-checking bench for pipe_arb_sched: directed scenarios plus a randomized run,
// all checked against a transaction-level model (rr pointer, outstanding count,
// expected-result queue with availability cycle).
module tb_pipe_arb_sched;

   localparam int unsigned N     = 10;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned ID_W  = 2;
   localparam int unsigned DEPTH = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a, req_b, req_c, req_d;
   logic              res_valid;
   logic              res_ready;
   logic [N-1:0]      res_data;
   logic [ID_W-1:0]   res_id;
   logic              busy;

   int unsigned op_a [NREQ];
   int unsigned op_b [NREQ];
   int unsigned op_c [NREQ];
   int unsigned op_d [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign req_a[g*N +: N] = N'(op_a[g]);
      assign req_b[g*N +: N] = N'(op_b[g]);
      assign req_c[g*N +: N] = N'(op_c[g]);
      assign req_d[g*N +: N] = N'(op_d[g]);
   end

   pipe_arb_sched #(.N(N), .NREQ(NREQ), .ID_W(ID_W), .OBUF_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .req_d     (req_d),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int data;
      int avail;
   } exp_t;

   exp_t exp_q[$];
   int   m_ptr, m_out, cyc, acc_idx;
   int   n_tests, n_fail;

   logic [NREQ-1:0] e_rdy, o_rdy;
   logic            e_vld, o_vld, e_busy, o_busy;
   int              e_data, e_id;
   logic [N-1:0]    o_data;
   logic [ID_W-1:0] o_id;

   task automatic model_clear();
      exp_q.delete();
      m_ptr   = 0;
      m_out   = 0;
      acc_idx = -1;
   endtask

   // One clock: sample DUT and model at the falling edge, advance model at the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      e_rdy = '0;
      if (m_out < int'(DEPTH)) begin
         for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            i = (m_ptr + k) % int'(NREQ);
            if (req_valid[i] && e_rdy == '0) e_rdy[i] = 1'b1;
         end
      end
      e_vld  = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      e_data = e_vld ? exp_q[0].data : 0;
      e_id   = e_vld ? exp_q[0].id : 0;
      e_busy = (m_out != 0);
      o_rdy  = req_ready;
      o_vld  = res_valid;
      o_data = res_data;
      o_id   = res_id;
      o_busy = busy;
      @(posedge clk);
      cyc++;
      acc_idx = -1;
      for (int i = 0; i < int'(NREQ); i++) if (e_rdy[i]) acc_idx = i;
      if (acc_idx >= 0) begin
         e.id    = acc_idx;
         e.data  = int'(((op_a[acc_idx] + op_b[acc_idx]) + (op_c[acc_idx] - op_d[acc_idx])
                         + op_d[acc_idx]) % (1 << N));
         e.avail = cyc + 3;
         exp_q.push_back(e);
         m_ptr = (acc_idx + 1) % int'(NREQ);
         m_out++;
      end
      if (e_vld && res_ready) begin
         e = exp_q.pop_front();
         m_out--;
      end
      #1;
   endtask

   task automatic rand_ops(input int i);
      op_a[i] = $urandom_range(0, 1023);
      op_b[i] = $urandom_range(0, 1023);
      op_c[i] = $urandom_range(0, 1023);
      op_d[i] = $urandom_range(0, 1023);
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_tests += 5;
      if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      if (res_data !== '0) begin n_fail++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
      if (res_id !== '0) begin n_fail++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = '0;
      model_clear();
   endtask

   task automatic single_issue(input string nm, input int a, input int b, input int c,
                               input int d, input int want);
      op_a[0] = a; op_b[0] = b; op_c[0] = c; op_d[0] = d;
      res_ready = 1'b1;
      req_valid = 4'b0001;
      tick();
      n_tests++;
      if (o_rdy !== 4'b0001) begin n_fail++; $display("FAIL %s_accept: got %b want 0001", nm, o_rdy); end
      req_valid = '0;
      for (int j = 1; j <= 6; j++) begin
         tick();
         n_tests++;
         if (o_vld !== (j == 4)) begin n_fail++; $display("FAIL %s_valid_c%0d: got %b want %b", nm, j, o_vld, j == 4); end
         if (j == 4) begin
            n_tests += 2;
            if (o_data !== N'(want)) begin n_fail++; $display("FAIL %s_data: got %0d want %0d", nm, o_data, want); end
            if (o_id !== '0) begin n_fail++; $display("FAIL %s_id: got %0d want 0", nm, o_id); end
         end
      end
   endtask

   task automatic test_single();
      single_issue("single", 1, 2, 10, 3, 13);
   endtask

   task automatic test_wrap();
      single_issue("wrap", 1000, 100, 0, 1, 76);
   endtask

   task automatic test_all_four();
      req_valid = '0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_clear();
      for (int i = 0; i < int'(NREQ); i++) rand_ops(i);
      res_ready = 1'b1;
      req_valid = 4'b1111;
      for (int k = 0; k < 24; k++) begin
         if (k == 16) req_valid = '0;
         tick();
         n_tests += e_vld ? 3 : 2;
         if (o_rdy !== e_rdy) begin n_fail++; $display("FAIL all4_rdy: got %b want %b", o_rdy, e_rdy); end
         if (o_vld !== e_vld) begin n_fail++; $display("FAIL all4_vld: got %b want %b", o_vld, e_vld); end
         if (e_vld && (o_data !== N'(e_data) || o_id !== ID_W'(e_id))) begin
            n_fail++; $display("FAIL all4_res: got id%0d/%0d want id%0d/%0d", o_id, o_data, e_id, e_data);
         end
         if (k < 16) begin
            n_tests++;
            if (acc_idx != k % 4) begin n_fail++; $display("FAIL all4_order: got %0d want %0d", acc_idx, k % 4); end
            if (acc_idx >= 0) rand_ops(acc_idx);
         end
         if (k >= 4 && k < 20) begin
            n_tests++;
            if (o_vld !== 1'b1) begin n_fail++; $display("FAIL all4_bubble_c%0d: got %b want 1", k, o_vld); end
         end
      end
   endtask

   task automatic test_backpressure();
      int n_acc, first_pop, first_acc;
      n_acc = 0; first_pop = -1; first_acc = -1;
      rand_ops(0);
      res_ready = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 14; k++) begin
         tick();
         n_tests += 2;
         if (o_rdy !== e_rdy) begin n_fail++; $display("FAIL bp_rdy: got %b want %b", o_rdy, e_rdy); end
         if (o_vld !== e_vld) begin n_fail++; $display("FAIL bp_vld: got %b want %b", o_vld, e_vld); end
         if (o_rdy[0]) begin n_acc++; rand_ops(0); end
      end
      n_tests++;
      if (n_acc != int'(DEPTH)) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", n_acc, DEPTH); end
      res_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (k == 20) req_valid = '0;
         tick();
         n_tests += e_vld ? 3 : 2;
         if (o_rdy !== e_rdy) begin n_fail++; $display("FAIL bp2_rdy: got %b want %b", o_rdy, e_rdy); end
         if (o_vld !== e_vld) begin n_fail++; $display("FAIL bp2_vld: got %b want %b", o_vld, e_vld); end
         if (e_vld && (o_data !== N'(e_data) || o_id !== ID_W'(e_id))) begin
            n_fail++; $display("FAIL bp2_res: got id%0d/%0d want id%0d/%0d", o_id, o_data, e_id, e_data);
         end
         if (first_pop < 0 && o_vld) first_pop = k;
         if (first_acc < 0 && o_rdy != '0) first_acc = k;
         if (o_rdy[0]) rand_ops(0);
      end
      n_tests++;
      if (first_acc != first_pop + 1) begin
         n_fail++; $display("FAIL bp_resume: accept at %0d want %0d", first_acc, first_pop + 1);
      end
   endtask

   task automatic test_reset_midflight();
      rand_ops(0);
      res_ready = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_tests++;
         if (o_rdy !== 4'b0001) begin n_fail++; $display("FAIL mid_fill: got %b want 0001", o_rdy); end
      end
      n_tests += 2;
      if (res_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", res_valid); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
      req_valid = 4'b1111;
      rst_n = 1'b0;
      #1;
      n_tests += 3;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", res_valid); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      if (req_ready !== '0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
      #1;
      rst_n = 1'b1;
      req_valid = '0;
      model_clear();
      res_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_tests += 2;
         if (o_vld !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %b want 0", o_vld); end
         if (o_busy !== e_busy) begin n_fail++; $display("FAIL mid_busy: got %b want %b", o_busy, e_busy); end
      end
      for (int i = 0; i < int'(NREQ); i++) rand_ops(i);
      req_valid = 4'b1111;
      tick();
      n_tests++;
      if (o_rdy !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", o_rdy); end
      req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_tests += e_vld ? 2 : 1;
         if (o_vld !== e_vld) begin n_fail++; $display("FAIL mid_vld: got %b want %b", o_vld, e_vld); end
         if (e_vld && (o_data !== N'(e_data) || o_id !== ID_W'(e_id))) begin
            n_fail++; $display("FAIL mid_res: got id%0d/%0d want id%0d/%0d", o_id, o_data, e_id, e_data);
         end
      end
   endtask

   task automatic test_full_pushpop_drop();
      int n_acc, n_id2;
      n_acc = 0; n_id2 = 0;
      rand_ops(0);
      rand_ops(1);
      rand_ops(2);
      res_ready = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (o_rdy[0]) begin n_acc++; rand_ops(0); end
      end
      n_tests++;
      if (n_acc != 8) begin n_fail++; $display("FAIL ff_fill: got %0d accepts want 8", n_acc); end
      req_valid = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin req_valid = '0; res_ready = 1'b1; end
         tick();
         n_tests++;
         if (o_rdy !== '0) begin n_fail++; $display("FAIL ff_nocredit_c%0d: got %b want 0", k, o_rdy); end
      end
      res_ready = 1'b0;
      req_valid = 4'b0010;
      tick();
      n_tests++;
      if (o_rdy !== 4'b0010) begin n_fail++; $display("FAIL ff_count_kept: got %b want 0010", o_rdy); end
      tick();
      n_tests++;
      if (o_rdy !== '0) begin n_fail++; $display("FAIL ff_refull: got %b want 0", o_rdy); end
      req_valid = '0;
      res_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         n_tests += e_vld ? 2 : 1;
         if (o_vld !== e_vld) begin n_fail++; $display("FAIL ff_vld: got %b want %b", o_vld, e_vld); end
         if (e_vld && (o_data !== N'(e_data) || o_id !== ID_W'(e_id))) begin
            n_fail++; $display("FAIL ff_res: got id%0d/%0d want id%0d/%0d", o_id, o_data, e_id, e_data);
         end
         if (o_vld && o_id == 2'd2) n_id2++;
      end
      n_tests++;
      if (n_id2 != 0) begin n_fail++; $display("FAIL ff_dropped_req2: got %0d results want 0", n_id2); end
   endtask

   task automatic test_random();
      int guard;
      req_valid = '0;
      for (int c = 0; c < 500; c++) begin
         if (acc_idx >= 0) req_valid[acc_idx] = 1'b0;
         for (int i = 0; i < int'(NREQ); i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               rand_ops(i);
               req_valid[i] = 1'b1;
            end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         res_ready = ($urandom_range(0, 3) != 0);
         tick();
         n_tests += e_vld ? 4 : 3;
         if (o_rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_rdy: got %b want %b", o_rdy, e_rdy); end
         if (o_vld !== e_vld) begin n_fail++; $display("FAIL rnd_vld: got %b want %b", o_vld, e_vld); end
         if (o_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy: got %b want %b", o_busy, e_busy); end
         if (e_vld && (o_data !== N'(e_data) || o_id !== ID_W'(e_id))) begin
            n_fail++; $display("FAIL rnd_res: got id%0d/%0d want id%0d/%0d", o_id, o_data, e_id, e_data);
         end
      end
      req_valid = '0;
      res_ready = 1'b1;
      guard = 0;
      while (exp_q.size() > 0 && guard < 40) begin
         tick();
         guard++;
         n_tests += e_vld ? 2 : 1;
         if (o_vld !== e_vld) begin n_fail++; $display("FAIL rnd_drain_vld: got %b want %b", o_vld, e_vld); end
         if (e_vld && (o_data !== N'(e_data) || o_id !== ID_W'(e_id))) begin
            n_fail++; $display("FAIL rnd_drain_res: got id%0d/%0d want id%0d/%0d", o_id, o_data, e_id, e_data);
         end
      end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain_timeout: %0d results left want 0", exp_q.size()); end
      tick();
      n_tests++;
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_busy: got %b want 0", o_busy); end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      cyc       = 0;
      rst_n     = 1'b0;
      res_ready = 1'b0;
      req_valid = '1;
      for (int i = 0; i < int'(NREQ); i++) rand_ops(i);
      model_clear();
      test_reset();
      test_single();
      test_wrap();
      test_all_four();
      test_backpressure();
      test_reset_midflight();
      test_full_pushpop_drop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
